// File: rtl/multicycle_control.sv
// Multi-cycle MIPS control unit: steps each instruction through FETCH/DECODE/EXEC/MEM/WB and
// drives datapath selects/enables, with memory handshakes, a wait timeout and a retire counter.
module multicycle_control #(
  parameter int unsigned FUNC_W          = 6,
  parameter int unsigned COUNT_W         = 32,
  parameter int unsigned MEM_TIMEOUT     = 16,
  parameter bit          HALT_ON_ILLEGAL = 1'b1
) (
  input  logic               clk_in,
  input  logic               reset_n_in,
  input  logic [5:0]         opcode_in,
  input  logic [FUNC_W-1:0]  func_in,
  input  logic               imem_ready_in,
  input  logic               dmem_ready_in,
  output logic               imem_req_out,
  output logic               ir_load_out,
  output logic               pc_enable_out,
  output logic               instr_mux_select_out,
  output logic               regfile_we_out,
  output logic               alu_mux_select_out,
  output logic [FUNC_W-1:0]  alu_func_out,
  output logic               data_mem_re_out,
  output logic               data_mem_we_out,
  output logic               data_mem_mux_select_out,
  output logic [1:0]         data_mem_size_out,
  output logic [2:0]         state_out,
  output logic               illegal_op_out,
  output logic               timeout_out,
  output logic [COUNT_W-1:0] retired_count_out
);

  typedef enum logic [2:0] {
    StFetch  = 3'd0,
    StDecode = 3'd1,
    StExec   = 3'd2,
    StMem    = 3'd3,
    StWb     = 3'd4,
    StHalt   = 3'd5
  } state_e;

  localparam logic [5:0] OpArith = 6'b000000;
  localparam logic [5:0] OpAddi  = 6'b001000;
  localparam logic [5:0] OpLw    = 6'b100011;
  localparam logic [5:0] OpSw    = 6'b101011;

  localparam logic [FUNC_W-1:0] FuncAdd = FUNC_W'(6'b100000);

  localparam bit          TimeoutEn      = (MEM_TIMEOUT != 0);
  localparam int unsigned WaitW          = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
  localparam int unsigned TimeoutLastInt = TimeoutEn ? MEM_TIMEOUT - 1 : 0;
  localparam logic [WaitW-1:0] TimeoutLast = WaitW'(TimeoutLastInt);

  state_e              state_q, state_d;
  logic [5:0]          op_q, op_d;
  logic [FUNC_W-1:0]   func_q, func_d;
  logic [WaitW-1:0]    wait_q, wait_d;
  logic                illegal_q, illegal_d;
  logic                timeout_q, timeout_d;
  logic [COUNT_W-1:0]  count_q, count_d;

  logic is_arith, is_addi, is_lw, is_sw, is_legal, wait_expired;

  assign is_arith = (op_q == OpArith);
  assign is_addi  = (op_q == OpAddi);
  assign is_lw    = (op_q == OpLw);
  assign is_sw    = (op_q == OpSw);
  assign is_legal = is_arith | is_addi | is_lw | is_sw;

  // The cycle that would bring the wait count up to MEM_TIMEOUT; ready in that cycle still wins.
  assign wait_expired = TimeoutEn && (wait_q == TimeoutLast);

  always_ff @(posedge clk_in) begin
    if (!reset_n_in) begin
      state_q   <= StFetch;
      op_q      <= '0;
      func_q    <= '0;
      wait_q    <= '0;
      illegal_q <= 1'b0;
      timeout_q <= 1'b0;
      count_q   <= '0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      func_q    <= func_d;
      wait_q    <= wait_d;
      illegal_q <= illegal_d;
      timeout_q <= timeout_d;
      count_q   <= count_d;
    end
  end

  // Next-state logic. The wait counter is zero in every state it is not counting in, so it is
  // already clear on each entry to FETCH or MEM.
  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    func_d    = func_q;
    wait_d    = '0;
    illegal_d = illegal_q;
    timeout_d = timeout_q;

    unique case (state_q)
      StFetch: begin
        if (imem_ready_in) begin
          op_d    = opcode_in;
          func_d  = func_in;
          state_d = StDecode;
        end else if (wait_expired) begin
          timeout_d = 1'b1;
          state_d   = StHalt;
        end else if (TimeoutEn) begin
          wait_d = wait_q + 1'b1;
        end
      end
      StDecode: begin
        if (is_legal) begin
          state_d = StExec;
        end else begin
          illegal_d = 1'b1;
          state_d   = HALT_ON_ILLEGAL ? StHalt : StFetch;
        end
      end
      StExec: begin
        state_d = (is_lw || is_sw) ? StMem : StWb;
      end
      StMem: begin
        if (dmem_ready_in) begin
          state_d = is_lw ? StWb : StFetch;
        end else if (wait_expired) begin
          timeout_d = 1'b1;
          state_d   = StHalt;
        end else if (TimeoutEn) begin
          wait_d = wait_q + 1'b1;
        end
      end
      StWb: begin
        state_d = StFetch;
      end
      StHalt: begin
        state_d = StHalt;
      end
      default: begin
        state_d = StHalt;
      end
    endcase
  end

  // Datapath controls. Only ir_load and the sw retire pulse look at the ready inputs.
  always_comb begin
    imem_req_out            = 1'b0;
    ir_load_out             = 1'b0;
    pc_enable_out           = 1'b0;
    instr_mux_select_out    = 1'b1;
    regfile_we_out          = 1'b0;
    alu_mux_select_out      = 1'b1;
    alu_func_out            = FuncAdd;
    data_mem_re_out         = 1'b0;
    data_mem_we_out         = 1'b0;
    data_mem_mux_select_out = 1'b1;

    unique case (state_q)
      StFetch: begin
        imem_req_out = 1'b1;
        ir_load_out  = imem_ready_in;
      end
      StDecode: begin
        pc_enable_out = ~is_legal & ~HALT_ON_ILLEGAL;
      end
      StExec: begin
        instr_mux_select_out = ~is_arith;
        alu_mux_select_out   = ~is_arith;
        alu_func_out         = is_arith ? func_q : FuncAdd;
      end
      StMem: begin
        alu_mux_select_out = 1'b1;
        alu_func_out       = FuncAdd;
        data_mem_re_out    = is_lw;
        data_mem_we_out    = is_sw;
        pc_enable_out      = is_sw & dmem_ready_in;
      end
      StWb: begin
        instr_mux_select_out    = is_arith;
        alu_mux_select_out      = ~is_arith;
        alu_func_out            = is_arith ? func_q : FuncAdd;
        regfile_we_out          = 1'b1;
        pc_enable_out           = 1'b1;
        data_mem_mux_select_out = is_lw;
      end
      default: begin
        imem_req_out = 1'b0;
      end
    endcase
  end

  assign count_d = count_q + COUNT_W'(pc_enable_out);

  assign data_mem_size_out = 2'b11;
  assign state_out         = state_q;
  assign illegal_op_out    = illegal_q;
  assign timeout_out       = timeout_q;
  assign retired_count_out = count_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Bench for multicycle_control: random instruction streams checked cycle by cycle against
// expected state traces built from the instruction latency rules.
module tb_multicycle_control;

  localparam int TimeoutA = 4;

  localparam logic [2:0] SFetch  = 3'd0;
  localparam logic [2:0] SDecode = 3'd1;
  localparam logic [2:0] SExec   = 3'd2;
  localparam logic [2:0] SMem    = 3'd3;
  localparam logic [2:0] SWb     = 3'd4;
  localparam logic [2:0] SHalt   = 3'd5;

  localparam logic [5:0] OpArith   = 6'b000000;
  localparam logic [5:0] OpAddi    = 6'b001000;
  localparam logic [5:0] OpLw      = 6'b100011;
  localparam logic [5:0] OpSw      = 6'b101011;
  localparam logic [5:0] OpIllegal = 6'b000010;
  localparam logic [5:0] FuncAdd   = 6'b100000;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n, imem_ready, dmem_ready;
  logic [5:0] opcode, func;

  logic        a_req, a_load, a_pc, a_imux, a_rfwe, a_amux, a_re, a_we, a_dmux, a_ill, a_to;
  logic [5:0]  a_afunc;
  logic [1:0]  a_size;
  logic [2:0]  a_state;
  logic [31:0] a_cnt;

  logic        b_req, b_load, b_pc, b_imux, b_rfwe, b_amux, b_re, b_we, b_dmux, b_ill, b_to;
  logic [5:0]  b_afunc;
  logic [1:0]  b_size;
  logic [2:0]  b_state;
  logic [2:0]  b_cnt;

  int total = 0;
  int bad   = 0;

  logic [31:0] m_count;
  logic        m_illegal, m_timeout;

  multicycle_control #(
    .FUNC_W(6), .COUNT_W(32), .MEM_TIMEOUT(TimeoutA), .HALT_ON_ILLEGAL(1'b1)
  ) dut_a (
    .clk_in(clk), .reset_n_in(rst_n), .opcode_in(opcode), .func_in(func),
    .imem_ready_in(imem_ready), .dmem_ready_in(dmem_ready),
    .imem_req_out(a_req), .ir_load_out(a_load), .pc_enable_out(a_pc),
    .instr_mux_select_out(a_imux), .regfile_we_out(a_rfwe), .alu_mux_select_out(a_amux),
    .alu_func_out(a_afunc), .data_mem_re_out(a_re), .data_mem_we_out(a_we),
    .data_mem_mux_select_out(a_dmux), .data_mem_size_out(a_size), .state_out(a_state),
    .illegal_op_out(a_ill), .timeout_out(a_to), .retired_count_out(a_cnt)
  );

  multicycle_control #(
    .FUNC_W(6), .COUNT_W(3), .MEM_TIMEOUT(0), .HALT_ON_ILLEGAL(1'b0)
  ) dut_b (
    .clk_in(clk), .reset_n_in(rst_n), .opcode_in(opcode), .func_in(func),
    .imem_ready_in(imem_ready), .dmem_ready_in(dmem_ready),
    .imem_req_out(b_req), .ir_load_out(b_load), .pc_enable_out(b_pc),
    .instr_mux_select_out(b_imux), .regfile_we_out(b_rfwe), .alu_mux_select_out(b_amux),
    .alu_func_out(b_afunc), .data_mem_re_out(b_re), .data_mem_we_out(b_we),
    .data_mem_mux_select_out(b_dmux), .data_mem_size_out(b_size), .state_out(b_state),
    .illegal_op_out(b_ill), .timeout_out(b_to), .retired_count_out(b_cnt)
  );

  // Leaves reset asserted; the next edge is also a reset edge and the following cycle is FETCH.
  task automatic do_reset();
    @(posedge clk); #1;
    rst_n      = 1'b0;
    imem_ready = 1'($urandom);
    dmem_ready = 1'($urandom);
    @(posedge clk); #1;
    m_count   = '0;
    m_illegal = 1'b0;
    m_timeout = 1'b0;
  endtask

  // One instruction on dut_a: id/dd are the imem/dmem wait cycles before ready.
  task automatic drive_instr(input logic [5:0] op, input logic [5:0] fn, input int id,
                             input int dd, output int ncyc, output int re_seen,
                             output int we_seen, output int rfwe_seen, output int pc_seen);
    logic [2:0] tr[$];
    logic [2:0] s;
    bit   legal, mem, f_to, m_to;
    int   fi, mi;
    logic e_req, e_load, e_pc, e_rfwe, e_re, e_we;
    legal = (op == OpArith) || (op == OpAddi) || (op == OpLw) || (op == OpSw);
    mem   = (op == OpLw) || (op == OpSw);
    f_to  = (id >= TimeoutA);
    m_to  = mem && (dd >= TimeoutA);
    for (int i = 0; i < (f_to ? TimeoutA : id + 1); i++) tr.push_back(SFetch);
    if (!f_to) begin
      tr.push_back(SDecode);
      if (legal) begin
        tr.push_back(SExec);
        if (mem) for (int i = 0; i < (m_to ? TimeoutA : dd + 1); i++) tr.push_back(SMem);
        if (!m_to && op != OpSw) tr.push_back(SWb);
      end
    end
    ncyc = 0; re_seen = 0; we_seen = 0; rfwe_seen = 0; pc_seen = 0; fi = 0; mi = 0;
    foreach (tr[k]) begin
      s = tr[k];
      @(posedge clk); #1;
      rst_n      = 1'b1;
      imem_ready = (s == SFetch) ? (fi == id) : 1'($urandom);
      dmem_ready = (s == SMem) ? (mi == dd) : 1'($urandom);
      if (s == SFetch && fi == id) begin
        opcode = op;
        func   = fn;
      end else begin
        opcode = 6'($urandom);
        func   = 6'($urandom);
      end
      @(negedge clk);
      e_req  = (s == SFetch);
      e_load = e_req && imem_ready;
      e_re   = (s == SMem) && (op == OpLw);
      e_we   = (s == SMem) && (op == OpSw);
      e_rfwe = (s == SWb);
      e_pc   = (s == SWb) || ((s == SMem) && (op == OpSw) && dmem_ready);
      total++;
      if (a_state !== s) begin
        bad++;
        $display("FAIL state op=%b cyc=%0d got=%0d exp=%0d", op, k, a_state, s);
      end
      total++;
      if ({a_req, a_load, a_pc, a_rfwe, a_re, a_we} !== {e_req, e_load, e_pc, e_rfwe, e_re, e_we})
      begin
        bad++;
        $display("FAIL enables op=%b cyc=%0d got=%b exp=%b", op, k,
                 {a_req, a_load, a_pc, a_rfwe, a_re, a_we},
                 {e_req, e_load, e_pc, e_rfwe, e_re, e_we});
      end
      if (s == SExec) begin
        total++;
        if ({a_amux, a_afunc} !== ((op == OpArith) ? {1'b0, fn} : {1'b1, FuncAdd})) begin
          bad++;
          $display("FAIL exec_alu op=%b got=%b_%b", op, a_amux, a_afunc);
        end
      end
      if (s == SExec && op == OpArith) begin
        total++;
        if (a_imux !== 1'b0) begin
          bad++;
          $display("FAIL exec_instr_mux got=%b exp=0", a_imux);
        end
      end
      if (s == SWb) begin
        total++;
        if ({a_imux, a_dmux} !== {op == OpArith, op == OpLw}) begin
          bad++;
          $display("FAIL wb_muxes op=%b got=%b%b", op, a_imux, a_dmux);
        end
      end
      if (s == SFetch || s == SDecode) begin
        total++;
        if ({a_imux, a_amux, a_afunc, a_dmux} !== {1'b1, 1'b1, FuncAdd, 1'b1}) begin
          bad++;
          $display("FAIL default_selects st=%0d got=%b", s, {a_imux, a_amux, a_afunc, a_dmux});
        end
      end
      total++;
      if (a_size !== 2'b11) begin
        bad++;
        $display("FAIL size got=%b exp=11", a_size);
      end
      total++;
      if ({a_ill, a_to, a_cnt} !== {m_illegal, m_timeout, m_count}) begin
        bad++;
        $display("FAIL flags_count got=%b%b/%0d exp=%b%b/%0d", a_ill, a_to, a_cnt,
                 m_illegal, m_timeout, m_count);
      end
      if (a_re)   re_seen++;
      if (a_we)   we_seen++;
      if (a_rfwe) rfwe_seen++;
      if (a_pc)   pc_seen++;
      if (e_pc) m_count++;
      if (s == SDecode && !legal) m_illegal = 1'b1;
      if ((s == SFetch && f_to && fi == TimeoutA - 1) || (s == SMem && m_to && mi == TimeoutA - 1))
        m_timeout = 1'b1;
      if (s == SFetch) fi++;
      if (s == SMem)   mi++;
      ncyc++;
    end
    if (f_to || !legal || m_to) begin
      repeat (2) begin
        @(posedge clk); #1;
        imem_ready = 1'($urandom);
        dmem_ready = 1'($urandom);
        opcode     = 6'($urandom);
        @(negedge clk);
        total++;
        if ({a_state, a_req, a_load, a_pc, a_rfwe, a_re, a_we} !== {SHalt, 6'b0}) begin
          bad++;
          $display("FAIL halt_idle got=%0d/%b", a_state, {a_req, a_load, a_pc, a_rfwe, a_re, a_we});
        end
        total++;
        if ({a_ill, a_to, a_cnt} !== {m_illegal, m_timeout, m_count}) begin
          bad++;
          $display("FAIL halt_flags got=%b%b/%0d exp=%b%b/%0d", a_ill, a_to, a_cnt,
                   m_illegal, m_timeout, m_count);
        end
      end
    end
  endtask

  task automatic test_reset();
    do_reset();
    @(negedge clk);
    total++;
    if ({a_state, a_pc, a_rfwe, a_re, a_we, a_ill, a_to} !== {SFetch, 6'b0}) begin
      bad++;
      $display("FAIL reset_state got=%0d/%b", a_state, {a_pc, a_rfwe, a_re, a_we, a_ill, a_to});
    end
    total++;
    if (a_cnt !== 32'd0 || b_cnt !== 3'd0) begin
      bad++;
      $display("FAIL reset_count got=%0d/%0d exp=0/0", a_cnt, b_cnt);
    end
  endtask

  task automatic test_add();
    int n, re, we, rf, pc;
    drive_instr(OpArith, FuncAdd, 0, 0, n, re, we, rf, pc);
    total++;
    if ({n, rf, pc} !== {32'd4, 32'd1, 32'd1}) begin
      bad++;
      $display("FAIL add_latency got=%0d/%0d/%0d exp=4/1/1", n, rf, pc);
    end
  endtask

  task automatic test_lw_wait();
    int n, re, we, rf, pc;
    drive_instr(OpLw, 6'($urandom), 0, 3, n, re, we, rf, pc);
    total++;
    if ({n, re, we, rf, pc} !== {32'd8, 32'd4, 32'd0, 32'd1, 32'd1}) begin
      bad++;
      $display("FAIL lw_wait got=%0d/%0d/%0d/%0d/%0d exp=8/4/0/1/1", n, re, we, rf, pc);
    end
  endtask

  task automatic test_sw();
    int n, re, we, rf, pc;
    drive_instr(OpSw, 6'($urandom), 0, 0, n, re, we, rf, pc);
    total++;
    if ({n, re, we, rf, pc} !== {32'd4, 32'd0, 32'd1, 32'd0, 32'd1}) begin
      bad++;
      $display("FAIL sw_store got=%0d/%0d/%0d/%0d/%0d exp=4/0/1/0/1", n, re, we, rf, pc);
    end
  endtask

  task automatic test_random();
    int n, re, we, rf, pc;
    logic [5:0] op;
    for (int i = 0; i < 40; i++) begin
      case ($urandom_range(0, 3))
        0:       op = OpArith;
        1:       op = OpAddi;
        2:       op = OpLw;
        default: op = OpSw;
      endcase
      drive_instr(op, 6'($urandom), int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                  n, re, we, rf, pc);
    end
  endtask

  task automatic test_reset_mid();
    @(posedge clk); #1;
    rst_n = 1'b1; imem_ready = 1'b1; dmem_ready = 1'b0; opcode = OpSw; func = 6'($urandom);
    repeat (3) begin
      @(posedge clk); #1;
      imem_ready = 1'b0;
      dmem_ready = 1'b0;
    end
    @(negedge clk);
    total++;
    if ({a_state, a_we, a_cnt} !== {SMem, 1'b1, m_count}) begin
      bad++;
      $display("FAIL mid_pre got=%0d/%b/%0d exp=3/1/%0d", a_state, a_we, a_cnt, m_count);
    end
    @(posedge clk); #1;
    rst_n      = 1'b0;
    dmem_ready = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    total++;
    if ({a_state, a_we, a_ill, a_to, a_cnt} !== {SFetch, 3'b000, 32'd0}) begin
      bad++;
      $display("FAIL mid_reset got=%0d/%b%b%b/%0d exp=0/000/0", a_state, a_we, a_ill, a_to, a_cnt);
    end
    m_count = '0; m_illegal = 1'b0; m_timeout = 1'b0;
  endtask

  task automatic test_timeout();
    int n, re, we, rf, pc;
    do_reset();
    drive_instr(OpLw, 6'($urandom), 0, 100, n, re, we, rf, pc);
    total++;
    if ({a_to, a_state, re} !== {1'b1, SHalt, 32'd4}) begin
      bad++;
      $display("FAIL mem_timeout got=%b/%0d/%0d exp=1/5/4", a_to, a_state, re);
    end
    do_reset();
    drive_instr(OpLw, 6'($urandom), 0, 3, n, re, we, rf, pc);
    total++;
    if ({a_to, pc} !== {1'b0, 32'd1}) begin
      bad++;
      $display("FAIL ready_at_limit got=%b/%0d exp=0/1", a_to, pc);
    end
    do_reset();
    drive_instr(OpArith, 6'($urandom), 100, 0, n, re, we, rf, pc);
    total++;
    if ({a_to, a_state, n} !== {1'b1, SHalt, 32'd4}) begin
      bad++;
      $display("FAIL fetch_timeout got=%b/%0d/%0d exp=1/5/4", a_to, a_state, n);
    end
  endtask

  task automatic test_illegal_halt();
    int n, re, we, rf, pc;
    do_reset();
    drive_instr(OpIllegal, 6'($urandom), 1, 0, n, re, we, rf, pc);
    total++;
    if ({a_ill, a_state, pc, rf} !== {1'b1, SHalt, 32'd0, 32'd0}) begin
      bad++;
      $display("FAIL illegal_halt got=%b/%0d/%0d/%0d exp=1/5/0/0", a_ill, a_state, pc, rf);
    end
  endtask

  // Non-halting variant with a 3-bit counter: nine NOP retires wrap the count to one.
  task automatic test_illegal_nop();
    logic [2:0] e_cnt;
    logic       e_ill;
    do_reset();
    e_cnt = '0;
    e_ill = 1'b0;
    for (int i = 0; i < 9; i++) begin
      @(posedge clk); #1;
      rst_n = 1'b1; imem_ready = 1'b1; opcode = OpIllegal; func = 6'($urandom);
      dmem_ready = 1'($urandom);
      @(negedge clk);
      total++;
      if ({b_state, b_load, b_pc} !== {SFetch, 1'b1, 1'b0}) begin
        bad++;
        $display("FAIL nop_fetch it=%0d got=%0d/%b%b", i, b_state, b_load, b_pc);
      end
      @(posedge clk); #1;
      imem_ready = 1'($urandom);
      opcode     = 6'($urandom);
      @(negedge clk);
      total++;
      if ({b_state, b_pc, b_rfwe, b_re, b_we} !== {SDecode, 4'b1000}) begin
        bad++;
        $display("FAIL nop_decode it=%0d got=%0d/%b", i, b_state, {b_pc, b_rfwe, b_re, b_we});
      end
      total++;
      if ({b_ill, b_cnt} !== {e_ill, e_cnt}) begin
        bad++;
        $display("FAIL nop_flags it=%0d got=%b/%0d exp=%b/%0d", i, b_ill, b_cnt, e_ill, e_cnt);
      end
      e_cnt = e_cnt + 3'd1;
      e_ill = 1'b1;
    end
    @(posedge clk); #1;
    imem_ready = 1'b0;
    @(negedge clk);
    total++;
    if ({b_state, b_ill, b_cnt} !== {SFetch, 1'b1, e_cnt}) begin
      bad++;
      $display("FAIL nop_wrap got=%0d/%b/%0d exp=0/1/%0d", b_state, b_ill, b_cnt, e_cnt);
    end
  endtask

  initial begin
    rst_n = 1'b1; imem_ready = 1'b0; dmem_ready = 1'b0; opcode = '0; func = '0;
    m_count = '0; m_illegal = 1'b0; m_timeout = 1'b0;
    test_reset();
    test_add();
    test_lw_wait();
    test_sw();
    test_random();
    test_reset_mid();
    test_timeout();
    test_illegal_halt();
    test_illegal_nop();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
